// File: rtl/operand_issue.sv
// Decode/issue stage ahead of execute; one-entry operand slot and a 32-bit busy scoreboard.
// Latency: 1 cycle from accepted instruction to out_valid. Backpressure: the slot holds while out_valid && !out_ready,
// and in_ready drops on a flush, on a RAW/WAW hazard, or while the slot is stalled.
module operand_issue #(
    parameter int         XLEN     = 32,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_sa,
    output logic [4:0]      rf_sb,
    input  logic [XLEN-1:0] rf_a,
    input  logic [XLEN-1:0] rf_b,
    output logic [4:0]      rf_da,
    output logic [XLEN-1:0] rf_d,
    output logic            rf_w,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [4:0]      out_rd,
    output logic            out_wr,
    output logic [31:0]     busy_mask
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            use_rs1, use_rs2, writes_rd;
    logic            byp1, byp2, rdy1, rdy2, wr_new, waw, hazard_free, fire;
    logic [XLEN-1:0] val1, val2;

    logic            out_valid_q;
    logic [XLEN-1:0] out_instr_q, out_pc_q, out_rs1_q, out_rs2_q;
    logic [4:0]      out_rd_q;
    logic            out_wr_q;
    logic [31:0]     busy_q, busy_d;

    assign opcode = in_instr[6:0];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign rd     = in_instr[11:7];

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1; end
            7'b0010011, 7'b0000011, 7'b1100111: begin use_rs1 = 1'b1; writes_rd = 1'b1; end
            7'b0100011, 7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0110111, 7'b0010111, 7'b1101111: writes_rd = 1'b1;
            default: ;
        endcase
    end

    assign rf_sa = rs1;
    assign rf_sb = rs2;
    assign rf_da = wb_rd;
    assign rf_d  = wb_data;
    assign rf_w  = wb_valid && (wb_rd != ZERO_REG);

    // The register file only updates at the edge, so a same-cycle write-back must be bypassed.
    assign byp1 = wb_valid && (wb_rd == rs1);
    assign byp2 = wb_valid && (wb_rd == rs2);
    assign rdy1 = (rs1 == ZERO_REG) || !busy_q[rs1] || byp1;
    assign rdy2 = (rs2 == ZERO_REG) || !busy_q[rs2] || byp2;
    assign val1 = (rs1 == ZERO_REG) ? '0 : (byp1 ? wb_data : rf_a);
    assign val2 = (rs2 == ZERO_REG) ? '0 : (byp2 ? wb_data : rf_b);

    assign wr_new      = writes_rd && (rd != ZERO_REG);
    assign waw         = wr_new && busy_q[rd] && !(wb_valid && (wb_rd == rd));
    assign hazard_free = (!use_rs1 || rdy1) && (!use_rs2 || rdy2) && !waw;
    assign in_ready    = !flush && hazard_free && (!out_valid_q || out_ready);
    assign fire        = in_valid && in_ready;

    // Set beats clear: a write-back and a new issue to the same register leave it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid)
            busy_d[wb_rd] = 1'b0;
        if (flush && out_valid_q && out_wr_q)
            busy_d[out_rd_q] = 1'b0;
        if (fire && wr_new)
            busy_d[rd] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            out_wr_q    <= 1'b0;
            busy_q      <= '0;
        end else begin
            busy_q <= busy_d;
            if (fire) begin
                out_valid_q <= 1'b1;
                out_instr_q <= in_instr;
                out_pc_q    <= in_pc;
                out_rs1_q   <= val1;
                out_rs2_q   <= val2;
                out_rd_q    <= rd;
                out_wr_q    <= wr_new;
            end else if (flush || out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_rs1_val = out_rs1_q;
    assign out_rs2_val = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_wr      = out_wr_q;
    assign busy_mask   = busy_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: expected slot contents are queued when offered and compared as the slot fills.
module tb_operand_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_sa, rf_sb, rf_da;
    logic [31:0] rf_a, rf_b, rf_d;
    logic        rf_w;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_wr;
    logic [31:0] busy_mask;

    operand_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_a(rf_a), .rf_b(rf_b),
        .rf_da(rf_da), .rf_d(rf_d), .rf_w(rf_w),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_wr(out_wr), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];
    exp_t nxt;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_rs1_val", out_rs1_val, 32'd0);
        chk("rst_rs2_val", out_rs2_val, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_wr", {31'd0, out_wr}, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                         input logic [4:0] erd, input logic ewr);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rf_a     = a;
        rf_b     = b;
        nxt      = '{instr: instr, pc: pc, rs1: e1, rs2: e2, rd: erd, wr: ewr};
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_instr = 32'd0;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    // One clock: check in_ready before the edge, advance the slot model, check the slot after the edge.
    task automatic tick(input logic exp_rdy, input logic [31:0] exp_busy);
        exp_t f;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        if (exp_q.size() > 0 && (out_ready || flush))
            void'(exp_q.pop_front());
        if (in_valid && exp_rdy)
            exp_q.push_back(nxt);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            f = exp_q[0];
            chk("out_instr", out_instr, f.instr);
            chk("out_pc", out_pc, f.pc);
            chk("out_rs1_val", out_rs1_val, f.rs1);
            chk("out_rs2_val", out_rs2_val, f.rs2);
            chk("out_rd", {27'd0, out_rd}, {27'd0, f.rd});
            chk("out_wr", {31'd0, out_wr}, {31'd0, f.wr});
        end
        chk("busy_mask", busy_mask, exp_busy);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        rf_a = 32'd0; rf_b = 32'd0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        flush = 1'b0; out_ready = 1'b1;
        #2;
        chk_reset_state();
        @(negedge clk);
        rst = 1'b1;

        // add x1,x2,x3
        offer(32'h003100B3, 32'h100, 32'd5, 32'd7, 32'd5, 32'd7, 5'd1, 1'b1);
        #1;
        chk("rf_sa", {27'd0, rf_sa}, 32'd2);
        chk("rf_sb", {27'd0, rf_sb}, 32'd3);
        tick(1'b1, 32'h0000_0002);

        // add x4,x1,x1 stalls on x1 until its write-back, then takes the bypassed value
        offer(32'h00108233, 32'h104, 32'hDEAD, 32'hDEAD, 32'h1234, 32'h1234, 5'd4, 1'b1);
        tick(1'b0, 32'h0000_0002);
        tick(1'b0, 32'h0000_0002);
        wb(1'b1, 5'd1, 32'h1234);
        #1;
        chk("rf_w_x1", {31'd0, rf_w}, 32'd1);
        chk("rf_da", {27'd0, rf_da}, 32'd1);
        chk("rf_d", rf_d, 32'h1234);
        tick(1'b1, 32'h0000_0010);
        wb(1'b0, 5'd0, 32'd0);

        // addi x5,x31,3: zero register reads as 0 despite rf_a
        offer(32'h003F8293, 32'h108, 32'hFFFF, 32'h77, 32'd0, 32'h77, 5'd5, 1'b1);
        tick(1'b1, 32'h0000_0030);

        // lui x31: no write flag, no busy bit; write-back to x31 never writes the file
        offer(32'h12345FB7, 32'h10C, 32'hA, 32'hB, 32'hA, 32'hB, 5'd31, 1'b0);
        wb(1'b1, 5'd31, 32'h99);
        #1;
        chk("rf_w_x31", {31'd0, rf_w}, 32'd0);
        tick(1'b1, 32'h0000_0030);
        wb(1'b0, 5'd0, 32'd0);

        // execute backpressure holds the slot for three cycles
        out_ready = 1'b0;
        offer(32'h00838333, 32'h110, 32'h11, 32'h22, 32'h11, 32'h22, 5'd6, 1'b1);
        repeat (3) tick(1'b0, 32'h0000_0030);
        out_ready = 1'b1;
        tick(1'b1, 32'h0000_0070);

        // retire x5, issue addi x5,x0,1 into a stalled slot, then flush it
        idle();
        wb(1'b1, 5'd5, 32'd0);
        tick(1'b1, 32'h0000_0050);
        wb(1'b0, 5'd0, 32'd0);
        out_ready = 1'b0;
        offer(32'h00100293, 32'h114, 32'd3, 32'd4, 32'd3, 32'd4, 5'd5, 1'b1);
        tick(1'b1, 32'h0000_0070);
        idle();
        flush = 1'b1;
        tick(1'b0, 32'h0000_0050);
        flush = 1'b0;
        out_ready = 1'b1;

        // drain x4 and x6, build busy = x1|x5, stall, then reset asynchronously
        wb(1'b1, 5'd4, 32'd0);
        tick(1'b1, 32'h0000_0040);
        wb(1'b1, 5'd6, 32'd0);
        tick(1'b1, 32'h0000_0000);
        wb(1'b0, 5'd0, 32'd0);
        offer(32'h00000093, 32'h118, 32'd1, 32'd2, 32'd1, 32'd2, 5'd1, 1'b1);
        tick(1'b1, 32'h0000_0002);
        offer(32'h00000293, 32'h11C, 32'd3, 32'd4, 32'd3, 32'd4, 5'd5, 1'b1);
        tick(1'b1, 32'h0000_0022);
        offer(32'h00108233, 32'h120, 32'd0, 32'd0, 32'd0, 32'd0, 5'd4, 1'b1);
        tick(1'b0, 32'h0000_0022);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state();
        exp_q.delete();
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Decode/issue stage directly upstream of the 32x32 register file.
- Accepts fetched RISC-V instructions and extracts rs1/rs2/rd. Drives the register file read selects and reads both operands in the same cycle.
- Tracks pending destination writes in a 32-bit scoreboard and stalls on RAW/WAW hazards.
- Registers the decoded operands into a valid/ready pipeline slot for execute. Also owns the register-file write port, driven from the write-back bus.

Parameters:
XLEN, 32, data width of operands and instructions
ZERO_REG, 31, register index hardwired to zero (reads 0, never written, never busy)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset (0 = reset)
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  XLEN  instruction word
in_pc  in  XLEN  instruction address
rf_sa  out  5  register file A select (= in_instr[19:15])
rf_sb  out  5  register file B select (= in_instr[24:20])
rf_a  in  XLEN  register file A bus
rf_b  in  XLEN  register file B bus
rf_da  out  5  register file write address (= wb_rd)
rf_d  out  XLEN  register file write data (= wb_data)
rf_w  out  1  register file write enable
wb_valid  in  1  write-back result valid
wb_rd  in  5  write-back destination
wb_data  in  XLEN  write-back value
flush  in  1  synchronous pipeline kill
out_valid  out  1  issue slot holds instruction
out_ready  in  1  execute consumes slot
out_instr, out_pc  out  XLEN  registered copies
out_rs1_val, out_rs2_val  out  XLEN  resolved operands
out_rd  out  5  destination
out_wr  out  1  instruction writes out_rd
busy_mask  out  32  scoreboard (debug)

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0; out_instr, out_pc, out_rs1_val, out_rs2_val, out_rd, out_wr=0; busy_mask=0.
- Operand-use decode by opcode in_instr[6:0]:
  - 0110011: use rs1, use rs2, write rd.
  - 0010011, 0000011, 1100111: use rs1, write rd.
  - 0100011, 1100011: use rs1, use rs2.
  - 0110111, 0010111, 1101111: write rd only.
  - Any other opcode: uses nothing, writes nothing; still issued.
- Write flag: out_wr = writes_rd && rd!=ZERO_REG.
- Write port (combinational): rf_da=wb_rd, rf_d=wb_data, rf_w = wb_valid && wb_rd!=ZERO_REG.
- Source ready: a used source is ready if rs==ZERO_REG, or busy[rs]==0, or (wb_valid && wb_rd==rs).
- Operand value:
  - 0 if rs==ZERO_REG.
  - Otherwise wb_data if wb_valid && wb_rd==rs (same-cycle bypass, since the register file updates only at the edge).
  - Otherwise rf_a / rf_b.
- WAW stall: when the instruction writes a non-zero rd and busy[rd]=1, it stalls unless wb_valid && wb_rd==rd this cycle.
- Ready/fire: in_ready = !flush && hazard_free && (!out_valid || out_ready). Fire = in_valid && in_ready; the slot loads on fire, latency 1 cycle.
- Slot drain: if out_valid && out_ready and no fire, out_valid->0. The slot holds stable while out_valid && !out_ready.
- Scoreboard update, per edge:
  - Clear busy[wb_rd] on wb_valid.
  - Then set busy[rd] on fire with out_wr; set wins over clear for the same register.
  - Write-back to a non-busy register writes the register file and leaves busy unchanged.
- Flush: next edge out_valid=0. If the slot held out_wr=1, busy[out_rd] is cleared (unless set by... n/a, since in_ready=0). Already-issued downstream instructions keep their busy bits.
- Simultaneous wb_valid and flush: both take effect.

Test Plan:
- Reset then issue `add x1,x2,x3` (0x003100B3) with rf_a=5, rf_b=7 → next cycle out_valid=1, out_rs1_val=5, out_rs2_val=7, out_rd=1, busy_mask=0x00000002.
- Back-to-back `add x1,...` then `add x4,x1,x1` with no write-back → second stalls (in_ready=0). Then wb_valid, wb_rd=1, wb_data=0x1234 → same cycle in_ready=1, operands=0x1234, busy[1] stays clear.
- Instruction with rs1=31 and rf_a=0xFFFF → out_rs1_val=0. Instruction with rd=31 → out_wr=0, busy_mask unchanged. wb_rd=31 → rf_w=0.
- Hold out_ready=0 for 3 cycles with a new instruction offered → in_ready=0, slot outputs constant. Raise out_ready → new instruction loads next edge.
- Flush with slot holding rd=5 → out_valid=0, busy[5]=0 next cycle.
- Assert rst=0 mid-stall with busy_mask=0x22 → outputs and busy_mask=0 immediately, without waiting for a clock edge.
